// File: rtl/tlc_pkg.sv
// Shared types and constants for the 4-approach traffic phase arbiter.
package tlc_pkg;
  localparam int NUM_APPR = 4;
  localparam int APPR_W   = 2;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    AMBER   = 2'd2
  } state_e;

  function automatic logic [NUM_APPR-1:0] appr_onehot(input logic [APPR_W-1:0] idx);
    appr_onehot      = '0;
    appr_onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/tlc_rr_pick.sv
// Rotate-priority picker: first set request strictly after ptr, wrapping around.
module tlc_rr_pick
  import tlc_pkg::*;
#(
  parameter int N = NUM_APPR,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any
);

  // Scan from farthest to nearest so the nearest set bit after ptr wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        winner = W'((int'(ptr) + i) % N);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_arbiter.sv
// Round-robin GREEN -> AMBER -> ALL_RED phase scheduler with min/max green,
// gap-out and emergency preemption. Lamps are registered from next-state.
//
//   state   | meaning
//   ALL_RED | clearance; all lamps red, arbitration at clearance end
//   GREEN   | approach cur has right-of-way
//   AMBER   | approach cur clearing, fixed duration
module tlc_phase_arbiter
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 10,
  parameter int AMBER_TIME = 3,
  parameter int CLEAR_TIME = 2,
  parameter int CNT_W      = 8
) (
  input  logic                clkdiv,
  input  logic                rst_n,
  input  logic [NUM_APPR-1:0] t,
  input  logic                emg,
  input  logic [APPR_W-1:0]   emg_dir,
  output logic [NUM_APPR-1:0] R,
  output logic [NUM_APPR-1:0] G,
  output logic [NUM_APPR-1:0] O,
  output logic [APPR_W-1:0]   phase,
  output logic                phase_valid
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [APPR_W-1:0]   cur_q, cur_d;
  logic [APPR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_APPR-1:0] lamp_r_q, lamp_r_d;
  logic [NUM_APPR-1:0] lamp_g_q, lamp_g_d;
  logic [NUM_APPR-1:0] lamp_o_q, lamp_o_d;
  logic [APPR_W-1:0]   phase_q, phase_d;
  logic                pv_q, pv_d;

  logic [APPR_W-1:0]   winner;
  logic                any_req;
  logic [NUM_APPR-1:0] cur_oh, nxt_oh;
  logic                competing, min_done, max_done, clear_done, amber_done;

  tlc_rr_pick #(.N(NUM_APPR), .W(APPR_W)) u_pick (
    .req    (t),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    ptr_d      = ptr_q;
    cur_oh     = appr_onehot(cur_q);
    competing  = |(t & ~cur_oh);
    min_done   = count_q >= CNT_W'(MIN_GREEN - 1);
    max_done   = count_q >= CNT_W'(MAX_GREEN - 1);
    clear_done = count_q >= CNT_W'(CLEAR_TIME - 1);
    amber_done = count_q == CNT_W'(AMBER_TIME - 1);

    case (state_q)
      ALL_RED: begin
        // Preemption grants emg_dir without disturbing round-robin fairness.
        if (clear_done) begin
          if (emg) begin
            state_d = GREEN;
            cur_d   = emg_dir;
          end else if (any_req) begin
            state_d = GREEN;
            cur_d   = winner;
            ptr_d   = winner;
          end
        end
      end
      GREEN: begin
        if (emg) begin
          if (emg_dir != cur_q) state_d = AMBER;
        end else if (min_done && competing && (!t[cur_q] || max_done)) begin
          state_d = AMBER;
        end
      end
      AMBER: begin
        if (amber_done) state_d = ALL_RED;
      end
      default: state_d = ALL_RED;
    endcase

    if (state_d != state_q)  count_d = '0;
    else if (count_q != '1)  count_d = count_q + CNT_W'(1);
    else                     count_d = count_q;

    nxt_oh   = appr_onehot(cur_d);
    lamp_r_d = '1;
    lamp_g_d = '0;
    lamp_o_d = '0;
    pv_d     = 1'b0;
    phase_d  = cur_d;
    case (state_d)
      GREEN: begin
        lamp_g_d = nxt_oh;
        lamp_r_d = ~nxt_oh;
        pv_d     = 1'b1;
      end
      AMBER: begin
        lamp_o_d = nxt_oh;
        lamp_r_d = ~nxt_oh;
        pv_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkdiv or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ALL_RED;
      count_q  <= '0;
      cur_q    <= '0;
      ptr_q    <= APPR_W'(NUM_APPR - 1);
      lamp_r_q <= '1;
      lamp_g_q <= '0;
      lamp_o_q <= '0;
      phase_q  <= '0;
      pv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      cur_q    <= cur_d;
      ptr_q    <= ptr_d;
      lamp_r_q <= lamp_r_d;
      lamp_g_q <= lamp_g_d;
      lamp_o_q <= lamp_o_d;
      phase_q  <= phase_d;
      pv_q     <= pv_d;
    end
  end

  assign R           = lamp_r_q;
  assign G           = lamp_g_q;
  assign O           = lamp_o_q;
  assign phase       = phase_q;
  assign phase_valid = pv_q;

endmodule
